sevenseg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an NDIGITS-digit common-anode seven-segment display. Holds one 7-bit display code per digit, cycles through the digits at a programmable rate, and drives the digit enables. Each slot starts with a blanking guard interval against ghosting, and leading zeros can optionally be suppressed. Sits directly upstream of the active-low seven-segment decoder: the `d` output feeds the decoder's 7-bit code input, and `an_n` drives the digit anodes.

---
 rtl/sevenseg_pkg.sv | 12 +
 rtl/sevenseg_scan_ctrl_if.sv | 13 +
 rtl/sevenseg_scan_ctrl_scan_timer.sv | 29 ++
 rtl/sevenseg_scan_ctrl.sv | 42 ++++
 tb/tb_sevenseg_scan_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: display-code type and constants shared by the scan controller
package sevenseg_pkg;
    typedef logic [6:0] disp_code_t;
    localparam disp_code_t BLANK_CODE = 7'b1000000;
    localparam disp_code_t DASH_CODE = 7'b0010000;
    localparam int BLANK_BIT = 6;
    localparam int DP_BIT = 5;
    localparam int DASH_BIT = 4;
    function automatic logic is_plain_zero(disp_code_t c);
        return !c[BLANK_BIT] && !c[DP_BIT] && !c[DASH_BIT] && c[3:0] == 4'h0;
    endfunction
endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// sevenseg_scan_ctrl_if: digit write port, suppression control and scan outputs
interface sevenseg_scan_ctrl_if #(parameter int NDIGITS = 8);
    import sevenseg_pkg::*;
    logic wr_en;
    logic [$clog2(NDIGITS)-1:0] wr_addr;
    disp_code_t wr_data;
    logic lz_en;
    disp_code_t d;
    logic [NDIGITS-1:0] an_n;
    logic frame_tick;
    modport master(output wr_en, wr_addr, wr_data, lz_en, input d, an_n, frame_tick);
    modport slave(input wr_en, wr_addr, wr_data, lz_en, output d, an_n, frame_tick);
endinterface

// File: rtl/sevenseg_scan_ctrl_scan_timer.sv
// scan_timer: slot counter and digit index; frame_wrap marks the first cycle after idx wraps to 0
module scan_timer #(
    parameter int NDIGITS = 8,
    parameter int SCAN_DIV = 100000,
    parameter int GUARD = 2,
    localparam int IW = $clog2(NDIGITS),
    localparam int CW = $clog2(SCAN_DIV)
) (
    input logic clk,
    input logic rst,
    output logic [IW-1:0] idx,
    output logic in_guard,
    output logic frame_wrap
);
    localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(NDIGITS - 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            frame_wrap <= 1'b0;
        end else begin
            cnt <= cnt == CMAX ? '0 : cnt + 1'b1;
            if (cnt == CMAX) idx <= idx == IMAX ? '0 : idx + 1'b1;
            frame_wrap <= cnt == CMAX && idx == IMAX;
        end
    assign in_guard = int'(cnt) < GUARD;
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed seven-segment scan with guard blanking and leading-zero suppression
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NDIGITS = 8,
    parameter int SCAN_DIV = 100000,
    parameter int GUARD = 2
) (
    input logic clk,
    input logic rst,
    sevenseg_scan_ctrl_if.slave bus
);
    localparam int IW = $clog2(NDIGITS);
    disp_code_t regs [NDIGITS];
    logic [IW-1:0] idx;
    logic in_guard, frame_wrap, run;
    logic [NDIGITS-1:0] supp;
    scan_timer #(.NDIGITS(NDIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) u_timer (
        .clk(clk), .rst(rst), .idx(idx), .in_guard(in_guard), .frame_wrap(frame_wrap)
    );
    // suppression ripples down from the top digit; a blank digit passes it on, anything else shown stops it
    always_comb begin
        supp = '0;
        run = bus.lz_en;
        for (int k = NDIGITS - 1; k > 0; k--) begin
            supp[k] = run && is_plain_zero(regs[k]);
            run = run && (supp[k] || regs[k][BLANK_BIT]);
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int k = 0; k < NDIGITS; k++) regs[k] <= BLANK_CODE;
            bus.d <= BLANK_CODE;
            bus.an_n <= '1;
            bus.frame_tick <= 1'b0;
        end else begin
            if (bus.wr_en && int'(bus.wr_addr) < NDIGITS) regs[bus.wr_addr] <= bus.wr_data;
            bus.d <= in_guard || supp[idx] ? BLANK_CODE : regs[idx];
            bus.an_n <= in_guard ? '1 : ~(NDIGITS'(1) << idx);
            bus.frame_tick <= frame_wrap;
        end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: directed checks on a 4-digit guarded instance and a 5-digit unguarded instance
module tb_sevenseg_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int e, checks, errors, first, second;
    sevenseg_scan_ctrl_if #(.NDIGITS(4)) ba();
    sevenseg_scan_ctrl_if #(.NDIGITS(5)) bb();
    sevenseg_scan_ctrl #(.NDIGITS(4), .SCAN_DIV(4), .GUARD(1)) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));
    sevenseg_scan_ctrl #(.NDIGITS(5), .SCAN_DIV(2), .GUARD(0)) dut_b (.clk(clk), .rst(rst), .bus(bb.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
        e++;
    endtask
    task automatic go(input int n);
        while (e < n) tick();
    endtask
    task automatic do_reset;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        e = 0;
    endtask
    task automatic chk_a(input string tag, input logic [3:0] an, input logic [6:0] d);
        chk($sformatf("%s_an", tag), ba.an_n, an);
        chk($sformatf("%s_d", tag), ba.d, d);
    endtask
    task automatic chk_b(input string tag, input logic [4:0] an, input logic [6:0] d);
        chk($sformatf("%s_an", tag), bb.an_n, an);
        chk($sformatf("%s_d", tag), bb.d, d);
    endtask
    task automatic load(input logic [6:0] v0, input logic [6:0] v1, input logic [6:0] v2, input logic [6:0] v3);
        logic [6:0] v [4];
        v = '{v0, v1, v2, v3};
        ba.wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ba.wr_addr = 2'(i);
            ba.wr_data = v[i];
            tick();
        end
        ba.wr_en = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        {ba.wr_en, ba.wr_addr, ba.wr_data, ba.lz_en} = '0;
        {bb.wr_en, bb.wr_addr, bb.wr_data, bb.lz_en} = '0;
        repeat (3) tick();
        chk_a("rst", 4'b1111, 7'h40);
        chk("rst_ft", ba.frame_tick, 0);
        rst = 1'b0;
        e = 0;
        tick();
        chk_a("e1_guard", 4'b1111, 7'h40);
        chk_b("b_e1", 5'b11110, 7'h40);
        tick();
        chk_a("e2_first", 4'b1110, 7'h40);
        chk_b("b_e2", 5'b11110, 7'h40);
        tick();
        chk_b("b_e3_noguard", 5'b11101, 7'h40);
        first = 0;
        second = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ba.frame_tick) begin
                if (first == 0) first = e;
                else if (second == 0) second = e;
            end
        end
        chk("ft_first", first, 17);
        chk("ft_period", second - first, 16);
        do_reset();
        load(7'h01, 7'h02, 7'h03, 7'h04);
        go(5);  chk_a("scan_g1", 4'b1111, 7'h40);
        go(6);  chk_a("scan_d1", 4'b1101, 7'h02);
        go(10); chk_a("scan_d2", 4'b1011, 7'h03);
        go(13); chk_a("scan_g3", 4'b1111, 7'h40);
        go(14); chk_a("scan_d3", 4'b0111, 7'h04);
        go(18); chk_a("scan_d0", 4'b1110, 7'h01);
        do_reset();
        ba.lz_en = 1'b1;
        load(7'h00, 7'h25, 7'h00, 7'h00);
        go(6);  chk_a("lz_d1", 4'b1101, 7'h25);
        go(10); chk_a("lz_d2", 4'b1011, 7'h40);
        go(14); chk_a("lz_d3", 4'b0111, 7'h40);
        go(18); chk_a("lz_d0", 4'b1110, 7'h00);
        ba.lz_en = 1'b0;
        go(26); chk_a("nolz_d2", 4'b1011, 7'h00);
        go(30); chk_a("nolz_d3", 4'b0111, 7'h00);
        do_reset();
        ba.lz_en = 1'b1;
        load(7'h00, 7'h00, 7'h20, 7'h00);
        go(6);  chk_a("dp_d1", 4'b1101, 7'h00);
        go(10); chk_a("dp_d2", 4'b1011, 7'h20);
        go(14); chk_a("dp_d3", 4'b0111, 7'h40);
        go(18); chk_a("dp_d0", 4'b1110, 7'h00);
        ba.lz_en = 1'b0;
        do_reset();
        go(10);
        chk_a("wa_pre", 4'b1011, 7'h40);
        ba.wr_en = 1'b1;
        ba.wr_addr = 2'd2;
        ba.wr_data = 7'h09;
        tick();
        ba.wr_en = 1'b0;
        chk_a("wa_e11", 4'b1011, 7'h40);
        tick();
        chk_a("wa_e12", 4'b1011, 7'h09);
        tick();
        chk_a("wa_e13", 4'b1111, 7'h40);
        do_reset();
        ba.wr_en = 1'b1;
        ba.wr_addr = 2'd1;
        ba.wr_data = 7'h11;
        bb.wr_en = 1'b1;
        bb.wr_addr = 3'd5;
        bb.wr_data = 7'h01;
        tick();
        ba.wr_en = 1'b0;
        bb.wr_addr = 3'd7;
        bb.wr_data = 7'h02;
        tick();
        bb.wr_addr = 3'd4;
        bb.wr_data = 7'h07;
        tick();
        bb.wr_en = 1'b0;
        go(5);  chk_b("ill_d2", 5'b11011, 7'h40);
        go(7);  chk_b("ill_d3", 5'b10111, 7'h40);
        go(9);  chk_b("ill_d4", 5'b01111, 7'h07);
        go(11); chk_b("ill_d0", 5'b11110, 7'h40);
        chk("b_ft", bb.frame_tick, 1);
        go(22); chk_a("mr_pre", 4'b1101, 7'h11);
        rst = 1'b1;
        #1;
        chk_a("mr_async", 4'b1111, 7'h40);
        chk_b("mr_async_b", 5'b11111, 7'h40);
        tick();
        tick();
        rst = 1'b0;
        e = 0;
        go(6);
        chk_a("mr_cleared", 4'b1101, 7'h40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
